// File: rtl/turn_pkg.sv
// Shared types and player-index helpers for the turn sequencer.
package turn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_CARD,
      ST_EVAL,
      ST_MOVE,
      ST_PASS,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      PC_2   = 2'b00,
      PC_3   = 2'b01,
      PC_4   = 2'b10,
      PC_BAD = 2'b11
   } pcount_e;

   // Highest legal player index for a legal player-count code.
   function automatic logic [1:0] last_player(input logic [1:0] code);
      return code + 2'd1;
   endfunction

   function automatic logic [1:0] next_player(input logic [1:0] cur,
                                              input logic [1:0] last);
      return (cur == last) ? 2'd0 : cur + 2'd1;
   endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn reveal timer: loadable up-counter with clear, enable and expiry flag.
module turn_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   localparam int unsigned W = $clog2(TIMEOUT_CYCLES)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expired_o
);

   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count_q, count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   // Holds at the expiry value so a stalled enable can never wrap the count.
   always_comb begin
      count_d = count_q;
      if (clear_i)                         count_d = '0;
      else if (load_i)                     count_d = load_val_i;
      else if (en_i && (count_q != LAST))  count_d = count_q + 1'b1;
   end

   assign expired_o = (count_q == LAST);

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer: owns the player index, streak and reveal/move handshakes.
module turn_controller
   import turn_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned STREAK_W       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          n_players,
   input  logic                card_valid,
   input  logic                card_match,
   input  logic                move_done,
   input  logic                win_flag,
   output logic [1:0]          cur_player,
   output logic                req_reveal,
   output logic                req_move,
   output logic                turn_end,
   output logic                timeout,
   output logic [STREAK_W-1:0] streak,
   output logic                game_over,
   output logic [1:0]          winner,
   output logic                cfg_err
);

   state_e              state_q, state_d;
   logic [1:0]          cur_q, cur_d;
   logic [1:0]          last_q, last_d;
   logic [1:0]          winner_q, winner_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                cfg_err_q, cfg_err_d;
   logic                match_q, match_d;
   logic                timeout_q, timeout_d;
   logic                expired;

   // Timer runs only in WAIT_CARD and is held at zero everywhere else,
   // which gives the clear-on-every-entry behaviour for free.
   turn_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   ((state_q != ST_WAIT_CARD) || abort),
      .load_i    (1'b0),
      .load_val_i('0),
      .en_i      (state_q == ST_WAIT_CARD),
      .expired_o (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         last_q    <= '0;
         winner_q  <= '0;
         streak_q  <= '0;
         cfg_err_q <= 1'b0;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         last_q    <= last_d;
         winner_q  <= winner_d;
         streak_q  <= streak_d;
         cfg_err_q <= cfg_err_d;
         match_q   <= match_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      last_d    = last_q;
      winner_d  = winner_q;
      streak_d  = streak_q;
      cfg_err_d = cfg_err_q;
      match_d   = match_q;
      timeout_d = 1'b0;

      if (abort) begin
         state_d  = ST_IDLE;
         cur_d    = '0;
         streak_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (n_players == PC_BAD) begin
                     cfg_err_d = 1'b1;
                  end else begin
                     last_d    = last_player(n_players);
                     cur_d     = '0;
                     streak_d  = '0;
                     cfg_err_d = 1'b0;
                     state_d   = ST_WAIT_CARD;
                  end
               end
            end
            ST_WAIT_CARD: begin
               if (card_valid) begin
                  match_d = card_match;
                  state_d = ST_EVAL;
               end else if (expired) begin
                  timeout_d = 1'b1;
                  state_d   = ST_PASS;
               end
            end
            ST_EVAL: begin
               state_d = match_q ? ST_MOVE : ST_PASS;
            end
            ST_MOVE: begin
               if (move_done) begin
                  if (win_flag) begin
                     winner_d = cur_q;
                     state_d  = ST_DONE;
                  end else begin
                     if (streak_q != '1) streak_d = streak_q + 1'b1;
                     state_d = ST_WAIT_CARD;
                  end
               end
            end
            ST_PASS: begin
               streak_d = '0;
               cur_d    = next_player(cur_q, last_q);
               state_d  = ST_WAIT_CARD;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign cur_player = cur_q;
   assign req_reveal = (state_q == ST_WAIT_CARD);
   assign req_move   = (state_q == ST_MOVE);
   assign turn_end   = (state_q == ST_PASS);
   assign timeout    = timeout_q;
   assign streak     = streak_q;
   assign game_over  = (state_q == ST_DONE);
   assign winner     = winner_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: expected events queued by stimulus, popped by a monitor.
module tb_turn_controller;

   localparam int unsigned TO = 8;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [1:0] n_players;
   logic       card_valid, card_match, move_done, win_flag;
   logic [1:0] cur_player, winner;
   logic       req_reveal, req_move, turn_end, timeout, game_over, cfg_err;
   logic [3:0] streak;

   turn_controller #(
      .TIMEOUT_CYCLES(TO),
      .STREAK_W      (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .n_players (n_players),
      .card_valid(card_valid),
      .card_match(card_match),
      .move_done (move_done),
      .win_flag  (win_flag),
      .cur_player(cur_player),
      .req_reveal(req_reveal),
      .req_move  (req_move),
      .turn_end  (turn_end),
      .timeout   (timeout),
      .streak    (streak),
      .game_over (game_over),
      .winner    (winner),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] cyc;
      logic [11:0] obs;
   } exp_t;

   exp_t       q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic       prev_rm = 1'b0;
   logic       prev_go = 1'b0;
   logic [1:0] exp_win = 2'd0;

   function automatic logic [11:0] pack_obs(input logic [1:0] c, input logic [3:0] s,
                                            input logic te, input logic to,
                                            input logic rm, input logic go,
                                            input logic [1:0] w);
      return {c, s, te, to, rm, go, w};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: an event is any pulse, or the rising edge of req_move / game_over.
   initial begin
      exp_t e;
      logic ev;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst) begin
            ev = turn_end || timeout || (req_move && !prev_rm) || (game_over && !prev_go);
            if (ev) begin
               if (q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_event: cycle %0d got cur=%0d te=%0b to=%0b rm=%0b go=%0b, required no event",
                           cyc, cur_player, turn_end, timeout, req_move, game_over);
               end else begin
                  e = q.pop_front();
                  chk("event_cycle", cyc, e.cyc);
                  chk("event_outputs",
                      32'(pack_obs(cur_player, streak, turn_end, timeout, req_move, game_over, winner)),
                      32'(e.obs));
               end
            end
         end
         prev_rm = req_move;
         prev_go = game_over;
      end
   end

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: got cycle budget exhausted, required bench completion");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start_game(input logic [1:0] code);
      n_players = code;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   // Mismatch: turn_end two cycles after card_valid; returns in the next WAIT_CARD.
   task automatic mismatch(input logic [1:0] c, input logic [3:0] s);
      card_valid = 1'b1;
      card_match = 1'b0;
      q.push_back('{cyc: 32'(cyc + 2), obs: pack_obs(c, s, 1'b1, 1'b0, 1'b0, 1'b0, exp_win)});
      step();
      card_valid = 1'b0;
      step();
      step();
   endtask

   // Match: req_move rises two cycles after card_valid; returns in MOVE.
   task automatic match(input logic [1:0] c, input logic [3:0] s);
      card_valid = 1'b1;
      card_match = 1'b1;
      q.push_back('{cyc: 32'(cyc + 2), obs: pack_obs(c, s, 1'b0, 1'b0, 1'b1, 1'b0, exp_win)});
      step();
      card_valid = 1'b0;
      card_match = 1'b0;
      step();
   endtask

   task automatic move(input logic win, input logic [1:0] c, input logic [3:0] s);
      move_done = 1'b1;
      win_flag  = win;
      if (win) begin
         exp_win = c;
         q.push_back('{cyc: 32'(cyc + 1), obs: pack_obs(c, s, 1'b0, 1'b0, 1'b0, 1'b1, c)});
      end
      step();
      move_done = 1'b0;
      win_flag  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; n_players = 2'b00;
      card_valid = 1'b0; card_match = 1'b0; move_done = 1'b0; win_flag = 1'b0;
      step();
      step();
      chk("reset_outputs",
          32'({cur_player, req_reveal, req_move, turn_end, timeout, streak, game_over, winner, cfg_err}), 32'd0);
      rst = 1'b0;
      step();

      // Illegal player count, then a legal start clears the flag.
      start_game(2'b11);
      chk("bad_cfg_err", 32'(cfg_err), 32'd1);
      chk("bad_stays_idle", 32'({req_reveal, game_over}), 32'd0);
      step();
      chk("bad_cfg_sticky", 32'(cfg_err), 32'd1);
      start_game(2'b01);
      chk("legal_clears_cfg", 32'(cfg_err), 32'd0);
      chk("start_req_reveal", 32'({req_reveal, cur_player}), 32'h4);

      // Three-player rotation 0 -> 1 -> 2 -> 0.
      mismatch(2'd0, 4'd0);
      mismatch(2'd1, 4'd0);
      mismatch(2'd2, 4'd0);
      chk("rotation_wrap", 32'({req_reveal, cur_player}), 32'h4);

      // Abort while player 1 is mid-move with a streak of 1.
      mismatch(2'd0, 4'd0);
      match(2'd1, 4'd0);
      move(1'b0, 2'd1, 4'd0);
      match(2'd1, 4'd1);
      chk("pre_abort_req_move", 32'(req_move), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_idle", 32'({req_move, req_reveal, cur_player, streak}), 32'd0);

      // Two-player game: streak 0 -> 1 -> 2, player 0 wins.
      start_game(2'b00);
      match(2'd0, 4'd0);
      move(1'b0, 2'd0, 4'd0);
      match(2'd0, 4'd1);
      move(1'b0, 2'd0, 4'd1);
      match(2'd0, 4'd2);
      move(1'b1, 2'd0, 4'd2);
      chk("win_done", 32'({game_over, winner, cur_player}), 32'h10);
      card_valid = 1'b1;
      card_match = 1'b1;
      step();
      card_valid = 1'b0;
      card_match = 1'b0;
      step();
      step();
      chk("done_ignores_card", 32'({game_over, req_move, streak}), 32'h22);

      // Restart from DONE with four players.
      start_game(2'b10);
      chk("restart", 32'({game_over, req_reveal, cur_player, streak, winner}), 32'h100);

      // Timeout: PASS with timeout TO cycles after WAIT_CARD entry.
      q.push_back('{cyc: 32'(cyc + int'(TO)), obs: pack_obs(2'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0)});
      repeat (TO + 1) step();
      chk("after_timeout_player", 32'({req_reveal, timeout, cur_player}), 32'h9);

      // Card on the expiry cycle wins over the timeout.
      repeat (TO - 1) step();
      card_valid = 1'b1;
      card_match = 1'b0;
      q.push_back('{cyc: 32'(cyc + 2), obs: pack_obs(2'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0)});
      step();
      card_valid = 1'b0;
      step();
      step();
      chk("expiry_card_player", 32'(cur_player), 32'd2);

      // Asynchronous reset in the middle of a move.
      match(2'd2, 4'd0);
      chk("pre_rst_req_move", 32'(req_move), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset",
          32'({cur_player, req_reveal, req_move, turn_end, timeout, streak, game_over, winner, cfg_err}), 32'd0);
      step();
      step();

      chk("pending_events", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
